// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in serial-out serializer and anything
// that needs to agree with its bit ordering (e.g. the deserializer's bench).
//
// Contents:
//   piso_state_t     - serializer FSM states (IDLE, SHIFT, PARITY)
//   SHIFT_LSB_FIRST  - SHIFT_DIR value: bit 0 goes out first
//   SHIFT_MSB_FIRST  - SHIFT_DIR value: bit SIZE-1 goes out first
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int SHIFT_LSB_FIRST = 0;
    localparam int SHIFT_MSB_FIRST = 1;

endpackage

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Bundles the word handshake, stall input and serial output of the
// serializer. clk/reset are kept outside the interface.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready
// are both 1. in_ready is registered and never depends on in_valid; in_data
// must be stable while in_valid is 1.
//
// Signals:
//   in_data    - parallel word (SIZE bits)
//   in_valid   - in_data is valid
//   in_ready   - serializer can accept a word (one-entry buffer empty)
//   hold       - downstream stall, freezes serialization
//   out        - serial bit
//   out_valid  - out is valid this cycle (drives deserializer enable)
//   first      - current bit is the first of a word
//   last       - current bit is the final bit of a word
//   busy       - a word is in the shifter
//   done       - one-cycle pulse after a word's final bit
//   parity_bit - current bit is the parity bit (PISO_PARITY_EN only)
//   fsm_state  - current FSM state, for observation
//
// Modports:
//   master - the upstream/word producer side
//   slave  - the serializer itself
//
// Build option: `define PISO_PARITY_EN adds the parity_bit signal.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int SIZE = 8
);
    import piso_pkg::*;

    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            hold;
    logic            out;
    logic            out_valid;
    logic            first;
    logic            last;
    logic            busy;
    logic            done;
`ifdef PISO_PARITY_EN
    logic            parity_bit;
`endif
    piso_state_t     fsm_state;

    modport master (
        output in_data, in_valid, hold,
        input  in_ready, out, out_valid, first, last, busy, done,
`ifdef PISO_PARITY_EN
        input  parity_bit,
`endif
        input  fsm_state
    );

    modport slave (
        input  in_data, in_valid, hold,
        output in_ready, out, out_valid, first, last, busy, done,
`ifdef PISO_PARITY_EN
        output parity_bit,
`endif
        output fsm_state
    );

endinterface

// File: rtl/piso_word_buffer.sv
// -----------------------------------------------------------------------------
// piso_word_buffer
// One-entry SIZE-wide holding buffer with valid/ready on both sides. Lets the
// next word wait while the shifter is still sending the current one.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_data/valid/ready  - write side; in_ready = buffer empty (registered)
//   out_data/valid/ready - read side; out_valid = buffer full
//
// A write is only possible while empty and a read only while full, so the
// two never happen on the same edge.
// -----------------------------------------------------------------------------
module piso_word_buffer #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    logic            full_q;
    logic [SIZE-1:0] data_q;

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (in_valid && in_ready) begin
                data_q <= in_data;
                full_q <= 1'b1;
            end else if (out_valid && out_ready) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out serializer feeding a SIPO deserializer. Accepts
// SIZE-bit words over valid/ready and sends one bit per clock with a per-bit
// strobe (out_valid). A one-entry buffer lets words stream back to back.
//
// Parameters:
//   SIZE      - word width (>= 2)
//   SHIFT_DIR - SHIFT_LSB_FIRST (0) or SHIFT_MSB_FIRST (1)
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - piso_serializer_if.slave (handshake, hold, serial outputs)
//
// Build option: `define PISO_PARITY_EN appends an even-parity bit to each
// word (PARITY state, parity_bit output, last moves to the parity cycle).
//
// Timing model: state/cnt/word describe the bit of the current cycle and the
// output registers are loaded from the next-state values, so every output is
// a flop. hold sampled on an edge makes the following cycle a held cycle.
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int SHIFT_DIR = SHIFT_LSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    piso_serializer_if.slave bus
);

    localparam int            CW       = $clog2(SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

    // FSM and datapath state
    piso_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] word_q, word_d;

    // registered outputs
    logic out_q, out_d;
    logic out_valid_q;
    logic first_q, first_d;
    logic last_q, last_d;
    logic done_q, done_d;
    logic parity_q, parity_d;
    logic present;

    // buffer hookup
    logic            buf_in_valid;
    logic            buf_in_ready;
    logic [SIZE-1:0] buf_data;
    logic            buf_full;
    logic            buf_pop;

    // routing
    logic            accept;
    logic            final_now;
    logic            route_direct;
    logic            direct;
    logic            load;
    logic [SIZE-1:0] load_word;
    logic [CW-1:0]   sel;

    // The word's final bit is being presented un-held this cycle.
`ifdef PISO_PARITY_EN
    assign final_now = out_valid_q && (state_q == PARITY);
`else
    assign final_now = out_valid_q && (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif

    // in_ready is the buffer's registered empty flag, so accept never loops
    // back through the routing decision.
    assign accept       = bus.in_valid && buf_in_ready;
    assign route_direct = (state_q == IDLE) || final_now;
    assign direct       = accept && route_direct;
    assign buf_in_valid = bus.in_valid && !route_direct;
    // When the buffer is full in_ready is 0, so pop and direct never coincide.
    assign buf_pop      = final_now && buf_full;
    assign load         = direct || buf_pop;
    assign load_word    = buf_pop ? buf_data : bus.in_data;

    piso_word_buffer #(
        .SIZE (SIZE)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .in_data   (bus.in_data),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .out_data  (buf_data),
        .out_valid (buf_full),
        .out_ready (buf_pop)
    );

    // Next state, counter and word register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        done_d  = 1'b0;

        if (final_now) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (load) begin
                state_d = SHIFT;
                word_d  = load_word;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        word_d  = load_word;
                    end
                end
                SHIFT: begin
                    // A held cycle leaves cnt pointing at the pending bit.
                    if (out_valid_q) begin
                        if (cnt_q != CNT_LAST) begin
                            cnt_d = cnt_q + 1'b1;
                        end
`ifdef PISO_PARITY_EN
                        else begin
                            state_d = PARITY;
                        end
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    // Only reached here while the parity cycle is held.
                    state_d = PARITY;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values for the next cycle.
    always_comb begin
        present  = (state_d != IDLE) && !bus.hold;
        sel      = (SHIFT_DIR == SHIFT_MSB_FIRST) ? (CNT_LAST - cnt_d) : cnt_d;
        out_d    = out_q;
        if (present) begin
            out_d = (state_d == PARITY) ? ^word_d : word_d[sel];
        end
        first_d  = present && (state_d == SHIFT) && (cnt_d == '0);
`ifdef PISO_PARITY_EN
        last_d   = present && (state_d == PARITY);
`else
        last_d   = present && (state_d == SHIFT) && (cnt_d == CNT_LAST);
`endif
        parity_d = present && (state_d == PARITY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            out_q       <= out_d;
            out_valid_q <= present;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
            parity_q    <= parity_d;
        end
    end

    assign bus.in_ready  = buf_in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.first     = first_q;
    assign bus.last      = last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.fsm_state = state_q;
`ifdef PISO_PARITY_EN
    assign bus.parity_bit = parity_q;
`else
    // Parity flag is not a port in this build.
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer (SIZE=8). Two instances share clk/reset:
// dut_lsb (LSB first) and dut_msb (MSB first). Inputs change and outputs are
// sampled on the falling clock edge. Observed vector layout everywhere:
//   {out, out_valid, first, last, busy, done, in_ready}
// With `define PISO_PARITY_EN only the reset and parity scenarios run.
// -----------------------------------------------------------------------------
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int SIZE = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    piso_serializer_if #(.SIZE(SIZE)) bus_lsb ();
    piso_serializer_if #(.SIZE(SIZE)) bus_msb ();

    piso_serializer #(
        .SIZE      (SIZE),
        .SHIFT_DIR (SHIFT_LSB_FIRST)
    ) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lsb)
    );

    piso_serializer #(
        .SIZE      (SIZE),
        .SHIFT_DIR (SHIFT_MSB_FIRST)
    ) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_msb)
    );

    logic [6:0] obs_lsb;
    logic [6:0] obs_msb;
    assign obs_lsb = {bus_lsb.out, bus_lsb.out_valid, bus_lsb.first, bus_lsb.last,
                      bus_lsb.busy, bus_lsb.done, bus_lsb.in_ready};
    assign obs_msb = {bus_msb.out, bus_msb.out_valid, bus_msb.first, bus_msb.last,
                      bus_msb.busy, bus_msb.done, bus_msb.in_ready};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus_lsb.in_data  = '0;
        bus_lsb.in_valid = 1'b0;
        bus_lsb.hold     = 1'b0;
        bus_msb.in_data  = '0;
        bus_msb.in_valid = 1'b0;
        bus_msb.hold     = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // accepting rising edge (ok=1), or after a bounded wait (ok=0).
    task automatic send_lsb(input logic [SIZE-1:0] data, output bit ok);
        ok = 1'b0;
        bus_lsb.in_data  = data;
        bus_lsb.in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (bus_lsb.in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        bus_lsb.in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_lsb !== 7'b0000001) begin
            miscompares++;
            $display("FAIL reset_lsb: got %b expected %b", obs_lsb, 7'b0000001);
        end
        vectors++;
        if (obs_msb !== 7'b0000001) begin
            miscompares++;
            $display("FAIL reset_msb: got %b expected %b", obs_msb, 7'b0000001);
        end
        vectors++;
        if (bus_lsb.fsm_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", bus_lsb.fsm_state, IDLE);
        end
`ifdef PISO_PARITY_EN
        vectors++;
        if (bus_lsb.parity_bit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_parity_bit: got %b expected 0", bus_lsb.parity_bit);
        end
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_lsb !== 7'b0000001) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b expected %b", obs_lsb, 7'b0000001);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] word;
        logic [7:0] rx;
        logic [6:0] exp;
        bit         ok;
        word = 8'hA5;
        rx   = '0;
        send_lsb(word, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_accept: got ok=%0d expected 1", ok);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {word[i], 1'b1, 1'(i == 0), 1'(i == 7), 1'b1, 1'b0, 1'b1};
            vectors++;
            if (obs_lsb !== exp) begin
                miscompares++;
                $display("FAIL single_bit%0d: got %b expected %b", i, obs_lsb, exp);
            end
            if (bus_lsb.out_valid === 1'b1) rx[i] = bus_lsb.out;
            @(negedge clk);
        end
        vectors++;
        if (obs_lsb[5:0] !== 6'b000011) begin
            miscompares++;
            $display("FAIL single_done: got %b expected %b", obs_lsb[5:0], 6'b000011);
        end
        vectors++;
        if (rx !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_deser_word: got %h expected a5", rx);
        end
        @(negedge clk);
        vectors++;
        if (obs_lsb[5:0] !== 6'b000001) begin
            miscompares++;
            $display("FAIL single_done_clear: got %b expected %b", obs_lsb[5:0], 6'b000001);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] order;  // element i = i-th bit on the wire for 8'h80
        logic [7:0] rx;
        logic [6:0] exp;
        order = 8'b0000_0001;
        rx    = '0;
        vectors++;
        if (bus_msb.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_ready: got %b expected 1", bus_msb.in_ready);
        end
        bus_msb.in_data  = 8'h80;
        bus_msb.in_valid = 1'b1;
        @(negedge clk);
        bus_msb.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {order[i], 1'b1, 1'(i == 0), 1'(i == 7), 1'b1, 1'b0, 1'b1};
            vectors++;
            if (obs_msb !== exp) begin
                miscompares++;
                $display("FAIL msb_bit%0d: got %b expected %b", i, obs_msb, exp);
            end
            rx = {rx[6:0], bus_msb.out};
            @(negedge clk);
        end
        vectors++;
        if (rx !== 8'h80) begin
            miscompares++;
            $display("FAIL msb_deser_word: got %h expected 80", rx);
        end
        vectors++;
        if (obs_msb[5:0] !== 6'b000011) begin
            miscompares++;
            $display("FAIL msb_done: got %b expected %b", obs_msb[5:0], 6'b000011);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;  // wire order, bit i sent i-th: 8'h01 then 8'hFE
        logic [6:0]  exp;
        int          done_cnt;
        int          valid_cnt;
        bit          ok;
        stream    = 16'hFE01;
        done_cnt  = 0;
        valid_cnt = 0;
        send_lsb(8'h01, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_accept0: got ok=%0d expected 1", ok);
        end
        for (int i = 0; i < 16; i++) begin
            exp = {stream[i], 1'b1, 1'(i == 0 || i == 8), 1'(i == 7 || i == 15),
                   1'b1, 1'(i == 8), 1'(!(i >= 1 && i <= 7))};
            vectors++;
            if (obs_lsb !== exp) begin
                miscompares++;
                $display("FAIL b2b_bit%0d: got %b expected %b", i, obs_lsb, exp);
            end
            if (bus_lsb.done === 1'b1) done_cnt++;
            if (bus_lsb.out_valid === 1'b1) valid_cnt++;
            if (i == 0) begin
                send_lsb(8'hFE, ok);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL b2b_accept1: got ok=%0d expected 1", ok);
                end
            end else begin
                @(negedge clk);
            end
        end
        vectors++;
        if (obs_lsb[5:0] !== 6'b000011) begin
            miscompares++;
            $display("FAIL b2b_end: got %b expected %b", obs_lsb[5:0], 6'b000011);
        end
        if (bus_lsb.done === 1'b1) done_cnt++;
        vectors++;
        if (done_cnt != 2) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt);
        end
        vectors++;
        if (valid_cnt != 16) begin
            miscompares++;
            $display("FAIL b2b_valid_count: got %0d expected 16", valid_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [7:0] word;
        logic [6:0] exp;
        int         b;
        int         gap;
        bit         held;
        bit         ok;
        word = 8'h3C;
        b    = 0;
        gap  = 0;
        send_lsb(word, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_accept: got ok=%0d expected 1", ok);
        end
        for (int c = 0; c < 11; c++) begin
            held = (c >= 4 && c <= 6);
            if (held) exp = {word[3], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            else      exp = {word[b], 1'b1, 1'(b == 0), 1'(b == 7), 1'b1, 1'b0, 1'b1};
            vectors++;
            if (obs_lsb !== exp) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got %b expected %b", c, obs_lsb, exp);
            end
            if (bus_lsb.out_valid !== 1'b1) gap++;
            if (!held) b++;
            bus_lsb.hold = (c >= 3 && c <= 5);
            @(negedge clk);
        end
        vectors++;
        if (gap != 3) begin
            miscompares++;
            $display("FAIL hold_gap: got %0d expected 3", gap);
        end
        vectors++;
        if (obs_lsb[5:0] !== 6'b000011) begin
            miscompares++;
            $display("FAIL hold_done: got %b expected %b", obs_lsb[5:0], 6'b000011);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w0;
        logic [7:0] w2;
        logic [6:0] exp;
        bit         ok;
        w0 = 8'h5A;
        w2 = 8'hC3;
        send_lsb(w0, ok);
        send_lsb(8'h99, ok);   // lands in the buffer
        repeat (4) @(negedge clk);
        exp = {w0[5], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs_lsb !== exp) begin
            miscompares++;
            $display("FAIL rst_mid_bit5: got %b expected %b", obs_lsb, exp);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (obs_lsb !== 7'b0000001) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %b expected %b", obs_lsb, 7'b0000001);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs_lsb[5:0] !== 6'b000001) begin
                miscompares++;
                $display("FAIL rst_mid_quiet%0d: got %b expected %b", i, obs_lsb[5:0], 6'b000001);
            end
        end
        send_lsb(w2, ok);
        for (int i = 0; i < 8; i++) begin
            exp = {w2[i], 1'b1, 1'(i == 0), 1'(i == 7), 1'b1, 1'b0, 1'b1};
            vectors++;
            if (obs_lsb !== exp) begin
                miscompares++;
                $display("FAIL rst_mid_new_bit%0d: got %b expected %b", i, obs_lsb, exp);
            end
            @(negedge clk);
        end
        vectors++;
        if (obs_lsb[5:0] !== 6'b000011) begin
            miscompares++;
            $display("FAIL rst_mid_new_done: got %b expected %b", obs_lsb[5:0], 6'b000011);
        end
        @(negedge clk);
        vectors++;
        if (obs_lsb[5:0] !== 6'b000001) begin
            miscompares++;
            $display("FAIL rst_mid_buffer_dropped: got %b expected %b", obs_lsb[5:0], 6'b000001);
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [8:0] wire_bits;  // 8'h07 LSB first, then even parity 1
        logic [6:0] exp;
        bit         ok;
        wire_bits = 9'b1_0000_0111;
        send_lsb(8'h07, ok);
        for (int i = 0; i < 9; i++) begin
            exp = {wire_bits[i], 1'b1, 1'(i == 0), 1'(i == 8), 1'b1, 1'b0, 1'b1};
            vectors++;
            if (obs_lsb !== exp) begin
                miscompares++;
                $display("FAIL parity_bit%0d: got %b expected %b", i, obs_lsb, exp);
            end
            vectors++;
            if (bus_lsb.parity_bit !== 1'(i == 8)) begin
                miscompares++;
                $display("FAIL parity_flag%0d: got %b expected %b", i, bus_lsb.parity_bit, 1'(i == 8));
            end
            @(negedge clk);
        end
        vectors++;
        if (obs_lsb[5:0] !== 6'b000011) begin
            miscompares++;
            $display("FAIL parity_done: got %b expected %b", obs_lsb[5:0], 6'b000011);
        end
        @(negedge clk);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
`ifdef PISO_PARITY_EN
        test_parity();
`else
        test_single_word();
        test_msb_first();
        test_back_to_back();
        test_hold();
        test_reset_mid_word();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that sits directly upstream of the SIPO deserializer. It accepts SIZE-bit words over a valid/ready handshake and emits one bit per cycle with a per-bit strobe that drives the deserializer's `enable`. Bit order matches the deserializer's SHIFT_DIR convention. A one-entry holding buffer lets consecutive words stream with no idle cycle between them.

## Interface
- `SIZE`, default 8: word width in bits; legal range SIZE ≥ 2.
- `SHIFT_DIR`, default 0: 0 = bit 0 sent first (LSB first); 1 = bit SIZE-1 sent first (MSB first).

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  SIZE  parallel word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word; transfer occurs on a rising edge with `in_valid && in_ready`.
- `hold`  in  1  downstream stall; freezes serialization.
- `out`  out  1  serial bit.
- `out_valid`  out  1  `out` is valid this cycle; wired to the deserializer's `enable`.
- `first`  out  1  current bit is the first bit of a word.
- `last`  out  1  current bit is the final bit of a word.
- `busy`  out  1  a word is in the shifter.
- `done`  out  1  one-cycle pulse after a word's final bit.
- `parity_bit`  out  1  current bit is the parity bit; present only when `PISO_PARITY_EN` is defined.

## Operation
- Reset values: `out`=0, `out_valid`=0, `first`=0, `last`=0, `busy`=0, `done`=0, `parity_bit`=0, `in_ready`=1. Bit counter is 0, buffer is empty, and the state is IDLE.
- Storage:
  - Shift register holds the word being sent.
  - One-entry buffer holds the next word.
  - Bit counter is `$clog2(SIZE)` bits wide and counts 0..SIZE-1, then wraps to 0.
- `in_ready` = buffer empty. It is registered and depends only on state, never on `in_valid`.
- Routing of an accepted word:
  - Goes straight into the shifter if the shifter is empty, or if it is presenting its final un-held bit this cycle and the buffer is empty.
  - Otherwise goes into the buffer.
- When the shifter completes a word and the buffer is full, the shifter loads from the buffer on that same edge.
- FSM:
  - IDLE → SHIFT on load.
  - SHIFT stays in SHIFT while counter < SIZE-1, or while `hold`=1.
  - SHIFT → (PARITY if enabled) → SHIFT if a next word is available, else IDLE.
- In SHIFT with `hold`=0:
  - `out` = word[cnt] when SHIFT_DIR=0, word[SIZE-1-cnt] when SHIFT_DIR=1.
  - `out_valid`=1.
  - `first` = (cnt==0).
  - `last` = (cnt==SIZE-1) when parity is disabled.
- `hold`=1:
  - `out_valid`, `first`, `last` and `parity_bit` go to 0.
  - `out` keeps its value, and the counter is frozen.
  - Handshake into the buffer continues normally.
- `busy` is 1 whenever the state is not IDLE.
- `done`=1 for exactly one cycle, the cycle after the final bit (data or parity) was presented un-held.
- Reset mid-word: the partial word and the buffered word are discarded, and no `done` is produced.

## Timing
- Latency: word accepted at edge N → first bit has `out_valid`=1 in the cycle after N.
- Throughput: one bit per cycle. Back-to-back words give SIZE (or SIZE+1) consecutive `out_valid` cycles with no gap.
- All outputs are registered, so there is no combinational path from any input to any output.
- Simultaneous `in_valid` during the final bit with an empty buffer: the word enters the shifter directly, and its first bit follows the final bit with no gap.
- Buffer-full edge: `in_ready` drops the cycle after the buffer fills and rises the cycle after the shifter drains it.

## Configuration
- `PISO_PARITY_EN` defined:
  - After the SIZE data bits, the block sends one extra cycle: `out` = ^word (even parity), `out_valid`=1, `parity_bit`=1.
  - `last` moves to the parity cycle.
  - A word occupies SIZE+1 cycles.
  - Downstream must gate the deserializer's `enable` with `!parity_bit`.
- `PISO_PARITY_EN` undefined: no PARITY state and no `parity_bit` port; a word occupies SIZE cycles.

## Structure
- Shared package `piso_pkg`: FSM state enum (IDLE, SHIFT, PARITY) and constants `SHIFT_LSB_FIRST`=0 and `SHIFT_MSB_FIRST`=1, shared with the deserializer's bench.
- One sub-module, `piso_word_buffer`: a one-entry SIZE-wide buffer with valid/ready on both sides.
- FSM, bit counter and shift register live in the top module.

## Test plan
- Single word, SIZE=8, SHIFT_DIR=0, in_data=8'hA5:
  - Bits 1,0,1,0,0,1,0,1 appear on 8 consecutive `out_valid` cycles.
  - `first` is set on the first bit and `last` on the eighth.
  - `done` pulses one cycle later.
  - When chained, the deserializer outputs 8'hA5.
- SHIFT_DIR=1, in_data=8'h80: the first bit is 1 and the remaining 7 bits are 0.
- Back-to-back words 8'h01 and 8'hFE presented on consecutive cycles:
  - `in_ready` drops after the second is accepted.
  - 16 contiguous `out_valid` cycles.
  - `done` pulses twice.
- `hold`=1 for 3 cycles after bit 3 of 8'h3C: `out_valid`=0 for exactly 3 cycles, then bit 4 resumes with no bit lost.
- `reset` asserted at bit 5 with the buffer full: all outputs return to reset values immediately, `in_ready`=1, and the next accepted word starts at bit 0.
- With `PISO_PARITY_EN`, in_data=8'h07: the ninth bit is 1, with `parity_bit`=1 and `last`=1 on that cycle.
